// File: rtl/or_1bit_checker_pkg.sv
// Shared types and constants for the 1-bit OR fabric vector checker.
// The LFSR constants are only consumed when OR_1BIT_CHECKER_RANDOM_EN is defined.
package or_1bit_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_APPLY,
    ST_SAMPLE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [3:0]  TRUTH_OR        = 4'b1110;
  localparam logic [11:0] VEC_SEQ_DEFAULT = 12'b00_01_10_11_01_10;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 with a left-shifting register
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/or_1bit_vector_checker_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load/step; exposes the low pair as {a,b}.
// Instantiated by the checker only when OR_1BIT_CHECKER_RANDOM_EN is defined.
module or_1bit_lfsr8
  import or_1bit_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [1:0] ab
);

  logic [7:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

  assign ab = q[1:0];

endmodule

// File: rtl/or_1bit_vector_checker.sv
// Drives directed {a,b} vectors into a 2-in/1-out fabric DUT and scores c against TRUTH.
// Define OR_1BIT_CHECKER_RANDOM_EN to append RAND_VEC LFSR-generated vectors.
module or_1bit_vector_checker
  import or_1bit_checker_pkg::*;
#(
  parameter int                   WARMUP   = 10,
  parameter int                   DRAIN    = 10,
  parameter int                   SETTLE   = 1,
  parameter int                   NUM_VEC  = 6,
  parameter logic [2*NUM_VEC-1:0] VEC_SEQ  = VEC_SEQ_DEFAULT,
  parameter logic [3:0]           TRUTH    = TRUTH_OR,
  parameter int                   CNT_W    = 4
`ifdef OR_1BIT_CHECKER_RANDOM_EN
  ,
  parameter int                   RAND_VEC = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail
);

`ifdef OR_1BIT_CHECKER_RANDOM_EN
  localparam int TOTAL = NUM_VEC + RAND_VEC;
`else
  localparam int TOTAL = NUM_VEC;
`endif

  localparam int MAX_WAIT = (WARMUP > DRAIN) ? ((WARMUP > SETTLE) ? WARMUP : SETTLE)
                                             : ((DRAIN > SETTLE) ? DRAIN : SETTLE);
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  localparam logic [WAIT_W-1:0] WARMUP_LD = WAIT_W'(WARMUP - 1);
  localparam logic [WAIT_W-1:0] DRAIN_LD  = WAIT_W'(DRAIN - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LD = WAIT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  NONE      = '1;

  // All-ones is reserved as "no failure", so the vector total must stay below it
  if (TOTAL > (1 << CNT_W) - 1) begin : g_cnt_w_check
    $error("or_1bit_vector_checker: CNT_W too narrow for the vector total");
  end
  if (WARMUP < 1 || DRAIN < 1 || SETTLE < 1) begin : g_wait_check
    $error("or_1bit_vector_checker: WARMUP, DRAIN and SETTLE must be at least 1");
  end

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  idx;
  logic [1:0]        vec_pair;
  logic              start_ok;
  logic              wait_zero;
  logic              last_vec;
  logic              match;

  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
  assign wait_zero = (wait_cnt == '0);
  assign last_vec  = (idx == LAST_IDX);
  assign match     = (dut_c == TRUTH[{dut_a, dut_b}]);

`ifdef OR_1BIT_CHECKER_RANDOM_EN
  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

  logic [1:0] rand_pair;

  or_1bit_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .step  ((state == ST_APPLY) && (idx >= NUM_VEC_C)),
    .ab    (rand_pair)
  );
`endif

  // Vector source: directed table first (MSB pair first), then the LFSR
  always_comb begin
    vec_pair = 2'b00;
    for (int k = 0; k < NUM_VEC; k++) begin
      if (idx == CNT_W'(k)) vec_pair = VEC_SEQ[2*(NUM_VEC-1-k) +: 2];
    end
`ifdef OR_1BIT_CHECKER_RANDOM_EN
    if (idx >= NUM_VEC_C) vec_pair = rand_pair;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE,
      ST_DONE:   if (start) next_state = ST_WARMUP;
      ST_WARMUP: if (wait_zero) next_state = ST_APPLY;
      ST_APPLY:  next_state = ST_SAMPLE;
      ST_SAMPLE: if (wait_zero) next_state = last_vec ? ST_DRAIN : ST_APPLY;
      ST_DRAIN:  if (wait_zero) next_state = ST_DONE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      idx        <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= NONE;
    end else if (start_ok) begin
      wait_cnt   <= WARMUP_LD;
      idx        <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= NONE;
    end else begin
      case (state)
        ST_WARMUP: begin
          if (!wait_zero) wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        ST_APPLY: begin
          dut_a    <= vec_pair[1];
          dut_b    <= vec_pair[0];
          wait_cnt <= SETTLE_LD;
        end
        // Score on the final settle cycle, then advance or start draining
        ST_SAMPLE: begin
          if (!wait_zero) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            if (match) begin
              pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              fail_cnt <= fail_cnt + CNT_W'(1);
              if (first_fail == NONE) first_fail <= idx;
            end
            if (last_vec) begin
              wait_cnt <= DRAIN_LD;
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!wait_zero) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (fail_cnt == '0) && (pass_cnt == TOTAL_C);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_or_1bit_vector_checker.sv
// Self-checking bench: a selectable fabric (OR / AND / stuck-at-1) behind the checker,
// scored against a vector-list model of the expected run.
module tb_or_1bit_vector_checker;

  localparam int          WARMUP  = 10;
  localparam int          DRAIN   = 10;
  localparam int          SETTLE  = 1;
  localparam int          NUM_VEC = 6;
  localparam int          CNT_W   = 4;
  localparam logic [11:0] VEC_SEQ = 12'b00_01_10_11_01_10;
  localparam logic [3:0]  TRUTH   = 4'b1110;
`ifdef OR_1BIT_CHECKER_RANDOM_EN
  localparam int          RAND_VEC = 8;
`else
  localparam int          RAND_VEC = 0;
`endif
  localparam int TOTAL    = NUM_VEC + RAND_VEC;
  localparam int VEC_STEP = 1 + SETTLE;
  localparam int RUN_LEN  = WARMUP + TOTAL * VEC_STEP + DRAIN;
  localparam int NONE     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             dut_a, dut_b, dut_c;
  logic             busy, done, pass;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail;

  int         fabric_mode = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [1:0] exp_vec [TOTAL];

  always #5 clk = ~clk;

  always_comb begin
    case (fabric_mode)
      1:       dut_c = dut_a & dut_b;
      2:       dut_c = 1'b1;
      default: dut_c = dut_a | dut_b;
    endcase
  end

  or_1bit_vector_checker #(
    .WARMUP  (WARMUP),
    .DRAIN   (DRAIN),
    .SETTLE  (SETTLE),
    .NUM_VEC (NUM_VEC),
    .VEC_SEQ (VEC_SEQ),
    .TRUTH   (TRUTH),
    .CNT_W   (CNT_W)
`ifdef OR_1BIT_CHECKER_RANDOM_EN
    , .RAND_VEC(RAND_VEC)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_c      (dut_c),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected score: the intended function is OR; the fabric may be broken
  task automatic model(input int mode, output int ep, output int ef, output int eff);
    logic a, b, want, got;
    ep = 0; ef = 0; eff = NONE;
    for (int k = 0; k < TOTAL; k++) begin
      a    = exp_vec[k][1];
      b    = exp_vec[k][0];
      want = a | b;
      got  = (mode == 1) ? (a & b) : (mode == 2) ? 1'b1 : (a | b);
      if (got == want) ep++;
      else begin
        ef++;
        if (eff == NONE) eff = k;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dut_a"}, dut_a, 0);
    check({tag, "_dut_b"}, dut_b, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_pass_cnt"}, pass_cnt, 0);
    check({tag, "_fail_cnt"}, fail_cnt, 0);
    check({tag, "_first_fail"}, first_fail, NONE);
  endtask

  task automatic run(input int mode, input string tag, input bit mid_start);
    int         ep, ef, eff, n;
    logic [1:0] seen [0:RUN_LEN];
    for (int i = 0; i <= RUN_LEN; i++) seen[i] = 2'b00;
    fabric_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_done_cleared"}, done, 0);
    n = 0;
    while (!done && n < RUN_LEN + 20) begin
      if (mid_start) start = (n == WARMUP + 4);
      tick();
      n++;
      if (n <= RUN_LEN) seen[n] = {dut_a, dut_b};
    end
    start = 1'b0;
    check({tag, "_latency"}, n, RUN_LEN);
    for (int k = 0; k < TOTAL; k++)
      check($sformatf("%s_vec%0d", tag, k), seen[WARMUP + 1 + k * VEC_STEP], exp_vec[k]);
    model(mode, ep, ef, eff);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_pass"}, pass, (ef == 0) ? 1 : 0);
    check({tag, "_pass_cnt"}, pass_cnt, ep);
    check({tag, "_fail_cnt"}, fail_cnt, ef);
    check({tag, "_first_fail"}, first_fail, eff);
    check({tag, "_held_stim"}, {dut_a, dut_b}, exp_vec[TOTAL-1]);
  endtask

  initial begin
    logic [11:0] seq;
    logic [7:0]  lfsr;
    seq = VEC_SEQ;
    for (int k = 0; k < NUM_VEC; k++) exp_vec[k] = seq[2*(NUM_VEC-1-k) +: 2];
    // Golden random stream: pair taken from the current state, then shift in the x^8+x^6+x^5+x^4+1 feedback
    lfsr = 8'hA5;
    for (int k = 0; k < RAND_VEC; k++) begin
      exp_vec[NUM_VEC + k] = lfsr[1:0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    tick();

    run(0, "or", 1'b0);
    run(1, "and", 1'b0);
    run(2, "stuck1", 1'b0);

    // Async reset during SAMPLE of vector 3
    fabric_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (WARMUP + 1 + 3 * VEC_STEP) tick();
    check("midrst_pre_vec", {dut_a, dut_b}, exp_vec[3]);
    check("midrst_pre_pass_cnt", pass_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(0, "after_rst", 1'b0);

    run(0, "busy_start", 1'b1);
    run(0, "post_done", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
